conv_line_sequencer: RTL and testbench

- Frame scheduler placed in front of the 3x3 convolution datapath.
- Accepts a raster-order pixel stream (one 8-bit pixel per beat) and buffers the two previous image rows in line memories.
- Emits one 3-pixel column word per beat on an AXI-Stream master, which feeds the convolution datapath's slave port directly.
- Sequences each frame from a start pulse with run-time width/height, marks end-of-frame with tlast, and reports done/error status.

---
 rtl/conv_line_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_conv_line_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_line_sequencer.sv
// conv_line_sequencer
//   Frame scheduler in front of a 3x3 convolution datapath. Takes a raster-order pixel
//   stream and keeps the two previous rows in line buffers. For every pixel from row 2
//   onward it emits one column word {0, row r, row r-1, row r-2} on an AXI-Stream master.
//
// Ports
//   s00_axis_aclk / s00_axis_rst : clock, synchronous active-high reset
//   start, cfg_width, cfg_height : frame launch with run-time geometry (sampled in idle)
//   busy, done, cfg_err          : status (done and cfg_err are one-cycle pulses)
//   frame_err                    : sticky input tlast mismatch, cleared by the next good start
//   s00_axis_*                   : pixel input, pixel in tdata[PIXEL_NB-1:0]
//   m00_axis_*                   : column-word output, tlast on the word for pixel (H-1, W-1)
module conv_line_sequencer #(
    parameter int unsigned ADDR_WIDTH         = 12,
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned PIXEL_NB           = 8,
    parameter int unsigned ROW_NB             = 12
) (
    input  logic                          s00_axis_aclk,
    input  logic                          s00_axis_rst,
    input  logic                          start,
    input  logic [ADDR_WIDTH:0]           cfg_width,
    input  logic [ROW_NB-1:0]             cfg_height,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err,
    output logic                          frame_err,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                          s00_axis_tvalid,
    output logic                          s00_axis_tready,
    input  logic                          s00_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                          m00_axis_tvalid,
    input  logic                          m00_axis_tready,
    output logic                          m00_axis_tlast
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MaxWidth = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {StIdle, StFill, StStream, StDrain, StDone} state_e;

    state_e                        state_q, state_d;
    logic [ADDR_WIDTH:0]           width_q, width_d;
    logic [ROW_NB-1:0]             height_q, height_d;
    logic [ROW_NB-1:0]             row_q, row_d;
    logic [ADDR_WIDTH-1:0]         col_q, col_d;
    logic                          cfg_err_q, cfg_err_d;
    logic                          frame_err_q, frame_err_d;
    logic                          m_valid_q, m_valid_d;
    logic                          m_last_q, m_last_d;
    logic [C_AXIS_TDATA_WIDTH-1:0] m_data_q, m_data_d;

    // lb0 holds row r-1, lb1 holds row r-2 (indexed by column)
    logic [PIXEL_NB-1:0] lb0_q [Depth];
    logic [PIXEL_NB-1:0] lb1_q [Depth];

    logic [PIXEL_NB-1:0]           pix;
    logic                          in_ready;
    logic                          in_acc;
    logic                          out_acc;
    logic                          end_of_row;
    logic                          last_row;
    logic                          last_pixel;
    logic                          cfg_bad;
    logic [C_AXIS_TDATA_WIDTH-1:0] col_word;
    logic                          unused_tdata;

    assign pix          = s00_axis_tdata[PIXEL_NB-1:0];
    assign unused_tdata = ^s00_axis_tdata[C_AXIS_TDATA_WIDTH-1:PIXEL_NB];

    assign end_of_row = ({1'b0, col_q} == (width_q - (ADDR_WIDTH + 1)'(1)));
    assign last_row   = (row_q == (height_q - ROW_NB'(1)));
    assign last_pixel = end_of_row && last_row;

    assign cfg_bad = (cfg_width == '0) || (cfg_width > MaxWidth) || (cfg_height < ROW_NB'(3));

    // Input is stalled whenever the output register holds an unaccepted word; reset gates
    // ready so a pixel offered during the reset cycle is never counted as consumed.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            StFill:   in_ready = 1'b1;
            StStream: in_ready = !m_valid_q || m00_axis_tready;
            default:  in_ready = 1'b0;
        endcase
        if (s00_axis_rst) begin
            in_ready = 1'b0;
        end
    end

    assign in_acc  = s00_axis_tvalid && in_ready;
    assign out_acc = m_valid_q && m00_axis_tready;

    // Read happens before the same-edge write, so the word sees the old row contents.
    always_comb begin
        col_word = '0;
        col_word[PIXEL_NB-1:0]              = lb1_q[col_q];
        col_word[2*PIXEL_NB-1 -: PIXEL_NB]  = lb0_q[col_q];
        col_word[3*PIXEL_NB-1 -: PIXEL_NB]  = pix;
    end

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        row_d       = row_q;
        col_d       = col_q;
        cfg_err_d   = 1'b0;
        frame_err_d = frame_err_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_data_d    = m_data_q;

        if (out_acc) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        width_d     = cfg_width;
                        height_d    = cfg_height;
                        frame_err_d = 1'b0;
                        row_d       = '0;
                        col_d       = '0;
                        state_d     = StFill;
                    end
                end
            end
            StFill, StStream: begin
                if (in_acc) begin
                    // Counts define the frame; tlast is only checked, never obeyed.
                    if (s00_axis_tlast != last_pixel) begin
                        frame_err_d = 1'b1;
                    end
                    if (end_of_row) begin
                        col_d = '0;
                        row_d = row_q + ROW_NB'(1);
                    end else begin
                        col_d = col_q + ADDR_WIDTH'(1);
                    end
                    if (state_q == StStream) begin
                        m_valid_d = 1'b1;
                        m_data_d  = col_word;
                        m_last_d  = last_pixel;
                        if (last_pixel) begin
                            state_d = StDrain;
                        end
                    end else if (end_of_row && (row_q == ROW_NB'(1))) begin
                        state_d = StStream;
                    end
                end
            end
            StDrain: begin
                if (out_acc) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_rst) begin
            state_q     <= StIdle;
            width_q     <= '0;
            height_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cfg_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cfg_err_q   <= cfg_err_d;
            frame_err_q <= frame_err_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_data_q    <= m_data_d;
        end
    end

    // Line buffers carry no reset; FILL rewrites every used column before it is read.
    always_ff @(posedge s00_axis_aclk) begin
        if (in_acc) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= pix;
        end
    end

    assign busy            = (state_q == StFill) || (state_q == StStream) || (state_q == StDrain);
    assign done            = (state_q == StDone);
    assign cfg_err         = cfg_err_q;
    assign frame_err       = frame_err_q;
    assign s00_axis_tready = in_ready;
    assign m00_axis_tdata  = m_data_q;
    assign m00_axis_tvalid = m_valid_q;
    assign m00_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_conv_line_sequencer.sv
// Self-checking bench for conv_line_sequencer: table of frame configurations, hand-written
// reset and config-error sequences, and randomized frames checked against a row-window model.
module tb_conv_line_sequencer;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int RW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   cfg_width;
    logic [RW-1:0] cfg_height;
    logic          busy, done, cfg_err, frame_err;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tready, s_tlast;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tready, m_tlast;

    conv_line_sequencer #(
        .ADDR_WIDTH(AW), .C_AXIS_TDATA_WIDTH(DW), .PIXEL_NB(8), .ROW_NB(RW)
    ) dut (
        .s00_axis_aclk(clk), .s00_axis_rst(rst), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .busy(busy), .done(done), .cfg_err(cfg_err), .frame_err(frame_err),
        .s00_axis_tdata(s_tdata), .s00_axis_tvalid(s_tvalid), .s00_axis_tready(s_tready),
        .s00_axis_tlast(s_tlast),
        .m00_axis_tdata(m_tdata), .m00_axis_tvalid(m_tvalid), .m00_axis_tready(m_tready),
        .m00_axis_tlast(m_tlast)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int w;
        int h;
        int vmode;      // 0 always valid, 1 random valid
        int rmode;      // 0 always ready, 1 pattern 1,0,0, 2 random
        int tlast_idx;  // pixel index carrying input tlast
        int pmode;      // 0 pixel = index, 1 random pixels
        bit exp_cfg_err;
        bit exp_ferr;
    } vec_t;

    vec_t          vecs[9];
    logic [7:0]    img[1024];
    logic [31:0]   got_data[$];
    logic          got_last[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cfg_err(input int w, input int h);
        @(negedge clk);
        start = 1'b1; cfg_width = (AW + 1)'(w); cfg_height = RW'(h);
        s_tvalid = 1'b1; s_tdata = 32'h55; m_tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
        chk("cfg_err_busy", 64'(busy), 64'd0);
        chk("cfg_err_in_ready", 64'(s_tready), 64'd0);
        @(negedge clk);
        #1;
        chk("cfg_err_low", 64'(cfg_err), 64'd0);
        chk("cfg_err_busy2", 64'(busy), 64'd0);
        s_tvalid = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input int vmode, input int rmode,
                             input int tlast_idx, input int pmode, input bit exp_ferr);
        int          n;
        int          pix;
        int          beats;
        int          cyc;
        bit          fin;
        bit          prev_stall;
        bit          last_acc;
        bit          in_acc;
        bit          out_acc;
        logic [31:0] pd;
        logic        pl;
        logic [32:0] e;
        logic [32:0] exp_q[$];

        n = w * h; pix = 0; beats = 0; cyc = 0; fin = 0; prev_stall = 0; last_acc = 0;
        pd = '0; pl = 1'b0;
        for (int i = 0; i < n; i++) img[i] = (pmode != 0) ? 8'($urandom) : 8'(i);
        // Each output word is the column (r-2, r-1, r) at column c, for rows 2..H-1.
        for (int r = 2; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                e = {(r == h - 1 && c == w - 1), 8'h00, img[r*w+c], img[(r-1)*w+c],
                     img[(r-2)*w+c]};
                exp_q.push_back(e);
            end
        end
        got_data.delete(); got_last.delete();

        @(negedge clk);
        start = 1'b1; cfg_width = (AW + 1)'(w); cfg_height = RW'(h);
        s_tvalid = 1'b0; m_tready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_ferr_clear", 64'(frame_err), 64'd0);

        while (!fin) begin
            if (pix < n) begin
                if (!s_tvalid || last_acc)
                    s_tvalid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 99) < 70);
                s_tdata = {24'h0, img[pix]};
                s_tlast = (pix == tlast_idx);
            end else begin
                s_tvalid = 1'b1;
                s_tdata  = 32'hDEAD_BEEF;
                s_tlast  = 1'b0;
            end
            case (rmode)
                0:       m_tready = 1'b1;
                1:       m_tready = (cyc % 3 == 0);
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
            #1;
            in_acc  = s_tvalid && s_tready;
            out_acc = m_tvalid && m_tready;
            if (prev_stall) begin
                chk("hold_valid", 64'(m_tvalid), 64'd1);
                chk("hold_data", 64'(m_tdata), 64'(pd));
                chk("hold_last", 64'(m_tlast), 64'(pl));
            end
            if (m_tvalid && !m_tready) chk("stall_in_ready", 64'(s_tready), 64'd0);
            prev_stall = m_tvalid && !m_tready;
            pd = m_tdata; pl = m_tlast;
            if (out_acc) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(m_tdata), 64'(e[31:0]));
                    chk("beat_last", 64'(m_tlast), 64'(e[32]));
                end
                got_data.push_back(m_tdata);
                got_last.push_back(m_tlast);
                beats++;
            end
            if (in_acc) begin
                if (pix >= n) chk("extra_accept", 64'd1, 64'd0);
                else pix++;
            end
            last_acc = in_acc;
            if (done) begin
                fin = 1;
                chk("done_busy", 64'(busy), 64'd0);
                chk("done_in_ready", 64'(s_tready), 64'd0);
                chk("beat_count", 64'(beats), 64'((h - 2) * w));
                chk("pixel_count", 64'(pix), 64'(n));
                chk("frame_err", 64'(frame_err), 64'(exp_ferr));
            end
            cyc++;
            if (!fin && cyc > 5000) begin
                chk("timeout_done", 64'd0, 64'd1);
                fin = 1;
            end
            if (!fin) @(negedge clk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(negedge clk);
        #1;
        chk("done_single_pulse", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_out_valid", 64'(m_tvalid), 64'd0);
    endtask

    initial begin
        logic [31:0] basic_exp[4];
        logic        basic_last[4];
        int          w, h, n, tl;

        basic_exp  = '{32'h0008_0400, 32'h0009_0501, 32'h000A_0602, 32'h000B_0703};
        basic_last = '{1'b0, 1'b0, 1'b0, 1'b1};

        vecs[0] = '{4, 3, 0, 0, 11, 0, 1'b0, 1'b0};
        vecs[1] = '{4, 4, 0, 1, 15, 1, 1'b0, 1'b0};
        vecs[2] = '{4, 2, 0, 0, 7, 0, 1'b1, 1'b0};
        vecs[3] = '{0, 3, 0, 0, 0, 0, 1'b1, 1'b0};
        vecs[4] = '{4097, 3, 0, 0, 0, 0, 1'b1, 1'b0};
        vecs[5] = '{3, 3, 0, 0, 4, 1, 1'b0, 1'b1};
        vecs[6] = '{3, 3, 1, 2, 8, 1, 1'b0, 1'b0};
        vecs[7] = '{1, 5, 1, 2, 4, 1, 1'b0, 1'b0};
        vecs[8] = '{17, 4, 1, 2, 67, 1, 1'b0, 1'b0};

        // Reset with input valid held high
        rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
        s_tvalid = 1'b1; s_tdata = 32'hFF; s_tlast = 1'b0; m_tready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(s_tready), 64'd0);
        chk("rst_out_valid", 64'(m_tvalid), 64'd0);
        chk("rst_out_data", 64'(m_tdata), 64'd0);
        chk("rst_out_last", 64'(m_tlast), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        rst = 1'b0; s_tvalid = 1'b0;

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].exp_cfg_err)
                run_cfg_err(vecs[v].w, vecs[v].h);
            else
                run_frame(vecs[v].w, vecs[v].h, vecs[v].vmode, vecs[v].rmode,
                          vecs[v].tlast_idx, vecs[v].pmode, vecs[v].exp_ferr);
            if (v == 0) begin
                chk("basic_beats", 64'(got_data.size()), 64'd4);
                for (int i = 0; i < 4 && i < got_data.size(); i++) begin
                    chk("basic_word", 64'(got_data[i]), 64'(basic_exp[i]));
                    chk("basic_tlast", 64'(got_last[i]), 64'(basic_last[i]));
                end
            end
        end

        // Reset during row 2 of a W=8, H=5 frame
        @(negedge clk);
        start = 1'b1; cfg_width = 13'd8; cfg_height = 12'd5;
        @(negedge clk);
        start = 1'b0; m_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_tvalid = 1'b1; s_tdata = 32'(i); s_tlast = 1'b0;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out_valid", 64'(m_tvalid), 64'd0);
        chk("midrst_out_last", 64'(m_tlast), 64'd0);
        chk("midrst_out_data", 64'(m_tdata), 64'd0);
        chk("midrst_in_ready", 64'(s_tready), 64'd0);
        rst = 1'b0; s_tvalid = 1'b0;
        run_frame(2, 3, 0, 0, 5, 1, 1'b0);
        chk("midrst_next_beats", 64'(got_data.size()), 64'd2);

        // Randomized frames against the model
        for (int k = 0; k < 8; k++) begin
            w  = $urandom_range(1, 20);
            h  = $urandom_range(3, 8);
            n  = w * h;
            tl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : n - 1;
            run_frame(w, h, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), tl, 1,
                      (tl != n - 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
